fib_multi_engine: RTL

Multi-channel iterative Fibonacci accelerator, the parametrised successor to the single-channel `Fib` callee. It accepts up to `CHANNELS` independent requests through per-channel req/busy handshakes, arbitrates them round-robin onto one shared iterative adder core, and returns fib(n) per channel. Overflow is flagged, and the result either wraps or saturates depending on a parameter. It sits below a generated `Main`-style top, which drives the req/n pairs and polls busy.

---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_rr_arbiter.sv | 71 +++++++
 rtl/fib_multi_engine.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the multi-channel Fibonacci engine: core state
// encoding, default sizing and the channel-index width helper.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } core_state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_N_WIDTH  = 8;
  localparam int DEF_CHANNELS = 4;

  function automatic int idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fib_rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel at or after the
// pointer, wrapping around; the pointer advances past each served channel.
module fib_rr_arbiter
  import fib_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int IDX_W    = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pending,
  input  logic                adv,
  input  logic [IDX_W-1:0]    adv_idx,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_valid
);

  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic [CHANNELS-1:0] grant_s;
  logic [IDX_W-1:0]    idx_s;
  logic                found_s;
  int                  cand_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant_s = {CHANNELS{1'b0}};
    idx_s   = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand_s = int'(ptr_q) + i;
      cand_s = (cand_s >= CHANNELS) ? (cand_s - CHANNELS) : cand_s;
      if (!found_s && pending[IDX_W'(cand_s)]) begin
        found_s                 = 1'b1;
        grant_s[IDX_W'(cand_s)] = 1'b1;
        idx_s                   = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the channel that just completed.
  always_comb begin
    if (adv) begin
      if (adv_idx == IDX_W'(CHANNELS - 1)) begin
        ptr_d = {IDX_W{1'b0}};
      end else begin
        ptr_d = adv_idx + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= {IDX_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign any_valid = found_s;

endmodule

// File: rtl/fib_multi_engine.sv
// Multi-channel iterative Fibonacci accelerator: per-channel request slots
// share one adder core, served round-robin, with wrap or saturate on overflow.
module fib_multi_engine
  import fib_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int N_WIDTH  = DEF_N_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SATURATE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  input  logic [CHANNELS*N_WIDTH-1:0] n,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS*WIDTH-1:0]   ret,
  output logic [CHANNELS-1:0]         ovf,
  output logic [CHANNELS-1:0]         done
);

  localparam int IDX_W = idx_w(CHANNELS);

  core_state_e                 state_q, state_d;
  logic [CHANNELS-1:0]         busy_q, busy_d;
  logic [CHANNELS*N_WIDTH-1:0] slot_q, slot_d;
  logic [CHANNELS*WIDTH-1:0]   ret_q, ret_d;
  logic [CHANNELS-1:0]         ovf_q, ovf_d;
  logic [CHANNELS-1:0]         done_q, done_d;
  logic [IDX_W-1:0]            gidx_q, gidx_d;
  logic [N_WIDTH-1:0]          count_q, count_d;
  logic [WIDTH-1:0]            a_q, a_d;
  logic [WIDTH-1:0]            b_q, b_d;
  logic                        ovfa_q, ovfa_d;
  logic                        ovfb_q, ovfb_d;

  logic [WIDTH:0]              sum_s;
  logic                        novf_s;
  logic                        adv_s;
  logic [CHANNELS-1:0]         grant_s;
  logic [IDX_W-1:0]            grant_idx_s;
  logic                        any_valid_s;

  // Only consulted in IDLE, when no channel is inside the core.
  fib_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .pending   (busy_q),
    .adv       (adv_s),
    .adv_idx   (gidx_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_valid_s)
  );

  // Slot acceptance, core FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    slot_d  = slot_q;
    ret_d   = ret_q;
    ovf_d   = ovf_q;
    done_d  = {CHANNELS{1'b0}};
    gidx_d  = gidx_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    ovfa_d  = ovfa_q;
    ovfb_d  = ovfb_q;
    adv_s   = 1'b0;
    sum_s   = {1'b0, a_q} + {1'b0, b_q};
    novf_s  = ovfa_q | ovfb_q | sum_s[WIDTH];

    for (int c = 0; c < CHANNELS; c++) begin
      if (req[c] && !busy_q[c]) begin
        busy_d[c]                     = 1'b1;
        slot_d[c*N_WIDTH +: N_WIDTH]  = n[c*N_WIDTH +: N_WIDTH];
      end else begin
        busy_d[c] = busy_d[c];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          gidx_d = grant_idx_s;
          for (int c = 0; c < CHANNELS; c++) begin
            if (grant_s[c]) begin
              count_d = slot_q[c*N_WIDTH +: N_WIDTH];
            end else begin
              count_d = count_d;
            end
          end
          a_d     = {WIDTH{1'b0}};
          b_d     = WIDTH'(1);
          ovfa_d  = 1'b0;
          ovfb_d  = 1'b0;
          state_d = ST_ITER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (count_q == N_WIDTH'(0)) begin
          state_d = ST_DONE;
        end else begin
          a_d     = b_q;
          ovfa_d  = ovfb_q;
          ovfb_d  = novf_s;
          count_d = count_q - N_WIDTH'(1);
          // Once saturating, later sums carry anyway so ovf stays sticky.
          if ((SATURATE != 0) && novf_s) begin
            b_d = {WIDTH{1'b1}};
          end else begin
            b_d = sum_s[WIDTH-1:0];
          end
        end
      end
      ST_DONE: begin
        if ((SATURATE != 0) && ovfa_q) begin
          ret_d[int'(gidx_q)*WIDTH +: WIDTH] = {WIDTH{1'b1}};
        end else begin
          ret_d[int'(gidx_q)*WIDTH +: WIDTH] = a_q;
        end
        ovf_d[gidx_q]  = ovfa_q;
        done_d[gidx_q] = 1'b1;
        busy_d[gidx_q] = 1'b0;
        adv_s          = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= {CHANNELS{1'b0}};
      slot_q  <= {(CHANNELS*N_WIDTH){1'b0}};
      ret_q   <= {(CHANNELS*WIDTH){1'b0}};
      ovf_q   <= {CHANNELS{1'b0}};
      done_q  <= {CHANNELS{1'b0}};
      gidx_q  <= {IDX_W{1'b0}};
      count_q <= {N_WIDTH{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      ovfa_q  <= 1'b0;
      ovfb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      slot_q  <= slot_d;
      ret_q   <= ret_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      gidx_q  <= gidx_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovfa_q  <= ovfa_d;
      ovfb_q  <= ovfb_d;
    end
  end

  assign busy = busy_q;
  assign ret  = ret_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule
